// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-vote sampling and a valid/ready output.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN (adds the parity_odd port).
module uart_rx_param #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rxd,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
    localparam int unsigned MID    = OVERSAMPLE / 2;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic [DIV_W-1:0]       div_cnt;
    logic [SAMP_W-1:0]      samp_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   smp_a, smp_b;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   ferr_q;
    logic                   armed_q;

    logic tick_c, at_m1_c, at_m_c, at_vote_c, at_end_c, vote_c;
    logic last_data_c, last_stop_c, start_c, done_c;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Tick and sample-point decode; >= keeps the divider from running away if baud_div shrinks
    assign tick_c      = (div_cnt >= baud_div);
    assign at_m1_c     = tick_c && (samp_cnt == SAMP_W'(MID - 1));
    assign at_m_c      = tick_c && (samp_cnt == SAMP_W'(MID));
    assign at_vote_c   = tick_c && (samp_cnt == SAMP_W'(MID + 1));
    assign at_end_c    = tick_c && (samp_cnt == SAMP_W'(OVERSAMPLE - 1));
    assign vote_c      = (smp_a & smp_b) | (smp_a & rxd_s) | (smp_b & rxd_s);
    assign last_data_c = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign last_stop_c = (bit_cnt == BIT_W'(STOP_BITS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and frame strobes
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rxd_s) begin
                    state_d = ST_START;
                    start_c = 1'b1;
                end
            end
            ST_START: begin
                if (at_vote_c && vote_c) begin
                    state_d = ST_IDLE;
                end else if (at_end_c) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_end_c && last_data_c) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_end_c) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (at_vote_c && last_stop_c) begin
                    state_d = ST_IDLE;
                    done_c  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Synchroniser, tick divider, sample/bit counters and receive shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '1;
            div_cnt  <= '0;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
            shift_q  <= '0;
            ferr_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};

            if (start_c || tick_c) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (start_c) begin
                samp_cnt <= '0;
            end else if (tick_c) begin
                samp_cnt <= at_end_c ? '0 : samp_cnt + SAMP_W'(1);
            end

            if (state_d != state_q) begin
                bit_cnt <= '0;
            end else if (at_end_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (at_m1_c) smp_a <= rxd_s;
            if (at_m_c)  smp_b <= rxd_s;

            if (state_q == ST_DATA && at_vote_c) begin
                shift_q <= {vote_c, shift_q[DATA_BITS-1:1]};
            end

            if (start_c) begin
                ferr_q <= 1'b0;
            end else if (state_q == ST_STOP && at_vote_c && !vote_c) begin
                ferr_q <= 1'b1;
            end

            // Re-arm only after a high level has been seen while sitting in IDLE
            armed_q <= (state_q == ST_IDLE) && (state_d == ST_IDLE) && (armed_q || rxd_s);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if (start_c) begin
            perr_q <= 1'b0;
        end else if (state_q == ST_PARITY && at_vote_c) begin
            perr_q <= vote_c ^ (^shift_q) ^ parity_odd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (done_c && (!rx_valid || rx_ready)) begin
            parity_err <= perr_q;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Output holding register with overrun detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            busy    <= (state_d != ST_IDLE);
            if (done_c) begin
                if (!rx_valid || rx_ready) begin
                    rx_data   <= shift_q;
                    frame_err <= ferr_q | ~vote_c;
                    rx_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param (default parameters, baud_div=3 -> 64 clk/bit).
// Parity vectors run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [15:0] baud_div;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
    logic       par_flip;
`endif

    int vec_cnt = 0;
    int miscompares = 0;
    int bit_clks = 64;
    int valid_cycles = 0;
    int ovr_pulses = 0;
    logic [7:0] last_data = '0;
    logic       last_ferr = 1'b0;
    logic       last_perr = 1'b0;

    uart_rx_param dut (
        .clk        (clk),
        .reset      (reset),
        .baud_div   (baud_div),
        .rxd        (rxd),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record delivered words and overrun pulses
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                valid_cycles <= valid_cycles + 1;
                last_data    <= rx_data;
                last_ferr    <= frame_err;
                last_perr    <= parity_err;
            end
            if (overrun) ovr_pulses <= ovr_pulses + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (bit_clks) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * bit_clks) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ parity_odd ^ par_flip);
`endif
        drive_bit(stop_v);
        rxd = 1'b1;
    endtask

    int v0, o0;
    logic [7:0] d6;

    initial begin
        reset    = 1'b1;
        baud_div = 16'd3;
        rxd      = 1'b1;
        rx_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        par_flip   = 1'b0;
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("reset_rx_valid", 32'(rx_valid), 32'd0);
        check_val("reset_rx_data", 32'(rx_data), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_frame_err", 32'(frame_err), 32'd0);
        check_val("reset_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        idle_bits(1);

        // Clean 0x55 frame
        v0 = valid_cycles; o0 = ovr_pulses;
        send_frame(8'h55, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check_val("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check_val("t1_data", 32'(last_data), 32'h55);
        check_val("t1_frame_err", 32'(last_ferr), 32'd0);
        check_val("t1_parity_err", 32'(last_perr), 32'd0);
        check_val("t1_overrun", 32'(ovr_pulses - o0), 32'd0);

        // False start: low for 4 ticks
        v0 = valid_cycles;
        rxd = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_val("t2_busy_mid", 32'(busy), 32'd1);
        repeat (8) @(posedge clk);
        rxd = 1'b1;
        repeat (48) @(posedge clk);
        @(negedge clk);
        check_val("t2_busy_end", 32'(busy), 32'd0);
        idle_bits(1);
        check_val("t2_no_valid", 32'(valid_cycles - v0), 32'd0);

        // Stop bit low, then clean recovery
        v0 = valid_cycles;
        send_frame(8'hA3, 1'b0);
        idle_bits(1);
        @(negedge clk);
        check_val("t3_data", 32'(last_data), 32'hA3);
        check_val("t3_frame_err", 32'(last_ferr), 32'd1);
        send_frame(8'h5A, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check_val("t3_next_data", 32'(last_data), 32'h5A);
        check_val("t3_next_frame_err", 32'(last_ferr), 32'd0);
        check_val("t3_valid_cycles", 32'(valid_cycles - v0), 32'd2);

        // Break: held low, one zero word with frame error, no restart
        v0 = valid_cycles;
        rxd = 1'b0;
        repeat (12 * bit_clks) @(posedge clk);
        @(negedge clk);
        check_val("brk_busy_low", 32'(busy), 32'd0);
        idle_bits(1);
        @(negedge clk);
        check_val("brk_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check_val("brk_data", 32'(last_data), 32'h00);
        check_val("brk_frame_err", 32'(last_ferr), 32'd1);

        // Overrun: consumer stalled across two frames
        o0 = ovr_pulses;
        @(negedge clk);
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle_bits(1);
        send_frame(8'h22, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check_val("t4_valid_held", 32'(rx_valid), 32'd1);
        check_val("t4_data_kept", 32'(rx_data), 32'h11);
        check_val("t4_overrun_once", 32'(ovr_pulses - o0), 32'd1);
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("t4_accepted", 32'(rx_valid), 32'd0);
        check_val("t4_accepted_data", 32'(rx_data), 32'h11);

        // Fastest divisor: tick every clock, 16 clk/bit
        baud_div = 16'd0;
        bit_clks = 16;
        idle_bits(2);
        v0 = valid_cycles;
        send_frame(8'h9C, 1'b1);
        idle_bits(2);
        @(negedge clk);
        check_val("div0_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check_val("div0_data", 32'(last_data), 32'h9C);
        baud_div = 16'd3;
        bit_clks = 64;
        idle_bits(1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check_val("t5_data_bad", 32'(last_data), 32'h07);
        check_val("t5_parity_err_bad", 32'(last_perr), 32'd1);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check_val("t5_parity_err_good", 32'(last_perr), 32'd0);
`endif

        // Reset in the middle of data bit 4 of 0xF0
        v0 = valid_cycles;
        d6 = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d6[i]);
        rxd = d6[4];
        repeat (32) @(posedge clk);
        @(negedge clk);
        check_val("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("t6_rx_valid", 32'(rx_valid), 32'd0);
        check_val("t6_rx_data", 32'(rx_data), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_frame_err", 32'(frame_err), 32'd0);
        check_val("t6_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        idle_bits(2);
        check_val("t6_no_partial", 32'(valid_cycles - v0), 32'd0);
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check_val("t6_next_data", 32'(last_data), 32'h3C);
        check_val("t6_next_frame_err", 32'(last_ferr), 32'd0);
        check_val("t6_next_valid_cycles", 32'(valid_cycles - v0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
